ccff_chain_loader: RTL and testbench

- Upstream driver of the configuration-chain head for a routing tile (connection/switch block).
- Accepts bitstream words over a valid/ready stream from the decrypt/unpack stage.
- Serialises exactly CHAIN_LEN bits, MSB first, onto ccff_head.
- Pulses config_enable only on cycles that carry a valid bit, so the downstream chain flops hold their contents during stalls.

---
 rtl/ccff_chain_loader.sv | 123 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises a word stream, MSB first, onto the
// configuration-chain head of a routing tile. config_enable strobes once per
// valid bit so the chain flops hold during input stalls.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 27,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] sr, sr_n;
  logic [WB_W-1:0]   wb, wb_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  fill_base;
  logic [31:0]       remain;
  logic [WB_W-1:0]   wb_fill;
  logic              hs;
  logic              last_bit;
  logic              final_bit;

  assign hs        = in_valid & in_ready;
  assign cnt_inc   = bit_cnt + CNT_W'(1);
  assign last_bit  = (wb == WB_W'(1));
  assign final_bit = ((32'(bit_cnt) + 32'd1) == 32'(CHAIN_LEN));
  assign busy      = (state == LOAD) || (state == SHIFT);
  assign done      = (state == DONE);

  // Bits to take from a freshly accepted word: a full word, or only what the
  // chain still needs, so the tail word's low bits are dropped.
  always_comb begin
    fill_base = (state == SHIFT) ? cnt_inc : bit_cnt;
    remain    = 32'(CHAIN_LEN) - 32'(fill_base);
    wb_fill   = (remain > 32'(WORD_W)) ? WB_W'(WORD_W) : WB_W'(remain);
  end

  // Next-state decode; abort wins over start and over a same-cycle handshake.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    wb_n    = wb;
    cnt_n   = bit_cnt;
    if (abort) begin
      state_n = IDLE;
      sr_n    = '0;
      wb_n    = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = LOAD;
            cnt_n   = '0;
          end
        end
        LOAD: begin
          if (hs) begin
            sr_n    = in_data;
            wb_n    = wb_fill;
            state_n = SHIFT;
          end
        end
        default: begin
          sr_n  = sr << 1;
          cnt_n = cnt_inc;
          wb_n  = wb - WB_W'(1);
          if (last_bit) begin
            if (final_bit) begin
              state_n = DONE;
            end else if (hs) begin
              // back-to-back word: reload without a bubble
              sr_n = in_data;
              wb_n = wb_fill;
            end else begin
              state_n = LOAD;
            end
          end
        end
      endcase
    end
  end

  // State and registered chain-facing outputs, all derived from next state.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state         <= IDLE;
      sr            <= '0;
      wb            <= '0;
      bit_cnt       <= '0;
      in_ready      <= 1'b0;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
    end else begin
      state         <= state_n;
      sr            <= sr_n;
      wb            <= wb_n;
      bit_cnt       <= cnt_n;
      in_ready      <= (state_n == LOAD) ||
                       ((state_n == SHIFT) && (wb_n == WB_W'(1)) &&
                        ((32'(cnt_n) + 32'd1) != 32'(CHAIN_LEN)));
      config_enable <= (state_n == SHIFT);
      ccff_head     <= (state_n == SHIFT) && sr_n[WORD_W-1];
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a bit-queue reference model checked against
// the DUT on every cycle, directed scenarios pinned by literal expectations,
// random traffic, and a second instance sized for an exact-multiple chain.
module tb_ccff_chain_loader;

  localparam int L = 27;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ccff_head, config_enable, busy, done;
  logic [4:0] bit_cnt;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(clk), .pReset(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ccff_head(ccff_head), .config_enable(config_enable), .busy(busy),
    .done(done), .bit_cnt(bit_cnt));

  logic       start16 = 1'b0, abort16 = 1'b0, valid16 = 1'b0;
  logic [7:0] data16 = 8'h00;
  logic       ready16, head16, en16, busy16, done16;
  logic [4:0] cnt16;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(clk), .pReset(rst_n), .start(start16), .abort(abort16),
    .in_data(data16), .in_valid(valid16), .in_ready(ready16),
    .ccff_head(head16), .config_enable(en16), .busy(busy16),
    .done(done16), .bit_cnt(cnt16));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model: phase 0 idle, 1 load, 2 shift, 3 done ----
  int m_phase = 0;
  int m_cnt   = 0;
  bit q[$];

  function automatic bit m_ready();
    return (m_phase == 1) || (m_phase == 2 && q.size() == 1 && m_cnt + 1 != L);
  endfunction

  task automatic push_word(input logic [7:0] d);
    int n;
    n = (W < L - m_cnt) ? W : L - m_cnt;
    for (int i = 0; i < n; i++) q.push_back(d[W-1-i]);
  endtask

  task automatic m_update(input bit rs, input bit st, input bit ab, input bit v,
                          input logic [7:0] d);
    bit rdy;
    rdy = m_ready();
    if (!rs || ab) begin
      m_phase = 0; m_cnt = 0; q.delete();
    end else begin
      case (m_phase)
        0, 3: if (st) begin m_phase = 1; m_cnt = 0; end
        1: if (v) begin push_word(d); m_phase = 2; end
        default: begin
          q.delete(0);
          m_cnt++;
          if (q.size() == 0) begin
            if (m_cnt == L) m_phase = 3;
            else if (v && rdy) push_word(d);
            else m_phase = 1;
          end
        end
      endcase
    end
  endtask

  // ---- per-load statistics ----
  int         obs, en_cnt, gap_cnt, first_done, hs_cnt;
  logic [26:0] seq;

  task automatic clear_stats();
    obs = 0; en_cnt = 0; gap_cnt = 0; first_done = -1; hs_cnt = 0; seq = '0;
  endtask

  task automatic step(input bit rs, input bit st, input bit ab, input bit v,
                      input logic [7:0] d);
    rst_n = rs; start = st; abort = ab; in_valid = v; in_data = d;
    @(posedge clk);
    if (rs && !ab && v && m_ready()) hs_cnt++;
    m_update(rs, st, ab, v, d);
    @(negedge clk);
    chk("in_ready",      32'(in_ready),      32'(m_ready()));
    chk("config_enable", 32'(config_enable), 32'(m_phase == 2));
    chk("ccff_head",     32'(ccff_head),     32'((m_phase == 2) ? q[0] : 1'b0));
    chk("busy",          32'(busy),          32'(m_phase == 1 || m_phase == 2));
    chk("done",          32'(done),          32'(m_phase == 3));
    chk("bit_cnt",       32'(bit_cnt),       32'(m_cnt));
    obs++;
    if (config_enable) begin
      seq = {seq[25:0], ccff_head};
      en_cnt++;
    end else if (en_cnt > 0 && en_cnt < L) begin
      gap_cnt++;
    end
    if (done && first_done < 0) first_done = obs;
  endtask

  logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'hE0};

  function automatic logic [7:0] stream_data();
    return (hs_cnt < 4) ? words[hs_cnt] : 8'($urandom);
  endfunction

  logic done_after_start;
  logic [4:0] cnt_after_start;

  task automatic run_load(input int stall_len);
    int  stall_left;
    bit  v;
    clear_stats();
    step(1, 1, 0, 0, 8'h00);
    done_after_start = done;
    cnt_after_start  = bit_cnt;
    stall_left = stall_len;
    for (int k = 0; k < 80 && m_phase != 3; k++) begin
      v = 1'b1;
      if (hs_cnt == 2 && m_ready() && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end
      step(1, 0, 0, v, stream_data());
    end
  endtask

  task automatic check_full(input string tag, input int exp_done, input int exp_gap);
    chk({tag, "_seq"},   32'(seq), 32'(27'b101001010011110011111111111));
    chk({tag, "_en"},    32'(en_cnt), 32'(27));
    chk({tag, "_done"},  32'(first_done), 32'(exp_done));
    chk({tag, "_hs"},    32'(hs_cnt), 32'(4));
    chk({tag, "_cnt"},   32'(bit_cnt), 32'(27));
    chk({tag, "_gap"},   32'(gap_cnt), 32'(exp_gap));
  endtask

  initial begin
    int         h16, late_ready, e16, got_done16;
    bit         hs_now;
    logic [15:0] s16;

    // reset state
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h55);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt",  32'(bit_cnt), 32'(0));

    // continuous stream
    run_load(0);
    check_full("cont", 29, 0);

    // start from DONE with a 5-cycle input stall after the 2nd word
    run_load(5);
    chk("restart_done", 32'(done_after_start), 32'(0));
    chk("restart_cnt",  32'(cnt_after_start), 32'(0));
    check_full("stall", 34, 5);

    // abort on the 10th shift cycle with start also high
    clear_stats();
    step(1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 40 && en_cnt < 10; k++) step(1, 0, 0, 1, stream_data());
    step(1, 1, 1, 1, stream_data());
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_cnt",  32'(bit_cnt), 32'(0));
    chk("abort_en",   32'(config_enable), 32'(0));
    chk("abort_rdy",  32'(in_ready), 32'(0));
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 8'hFF);
    chk("abort_quiet", 32'(en_cnt), 32'(10));
    run_load(0);
    check_full("reload", 29, 0);

    // synchronous reset mid-shift, start held during reset
    clear_stats();
    step(1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 40 && en_cnt < 5; k++) step(1, 0, 0, 1, stream_data());
    step(0, 1, 0, 1, 8'hFF);
    chk("srst_outs", 32'({in_ready, ccff_head, config_enable, busy, done, bit_cnt}), 32'(0));
    step(1, 0, 0, 1, 8'hFF);
    chk("srst_idle", 32'({busy, in_ready}), 32'(0));

    // random traffic against the model
    for (int k = 0; k < 3000; k++)
      step(($urandom % 200) != 0, ($urandom % 20) == 0, ($urandom % 60) == 0,
           ($urandom % 4) != 0, 8'($urandom));
    step(1, 0, 1, 0, 8'h00);

    // exact-multiple chain: 16 bits from 0x81, 0x01
    h16 = 0; late_ready = 0; e16 = 0; s16 = '0; got_done16 = 0;
    @(negedge clk);
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    valid16 = 1'b1;
    for (int k = 0; k < 30 && !got_done16; k++) begin
      if (en16) begin s16 = {s16[14:0], head16}; e16++; end
      if (h16 >= 2 && ready16) late_ready++;
      if (done16) got_done16 = 1;
      data16 = (h16 == 0) ? 8'h81 : (h16 == 1) ? 8'h01 : 8'hFF;
      hs_now = ready16 & valid16;
      @(posedge clk);
      if (hs_now) h16++;
      @(negedge clk);
    end
    valid16 = 1'b0;
    chk("x16_seq",   32'(s16), 32'(16'b1000000100000001));
    chk("x16_en",    32'(e16), 32'(16));
    chk("x16_hs",    32'(h16), 32'(2));
    chk("x16_ready", 32'(late_ready), 32'(0));
    chk("x16_done",  32'(done16), 32'(1));
    chk("x16_cnt",   32'(cnt16), 32'(16));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
